modsub_arbiter: RTL and testbench

MODSUB_ARBITER -- requirements
Module: modsub_arbiter

---
 rtl/modsub_arbiter_pkg.sv | 19 +
 rtl/modsub_tag_pipe.sv | 45 ++++
 rtl/modsub_arbiter.sv | 166 ++++++++++++++++
 tb/tb_modsub_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modsub_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// modsub_arbiter_pkg
//   Shared constants and helpers for the modular-subtractor arbiter slice.
//   DEF_W    : default operand/result width
//   DEF_NREQ : default number of requesters
//   Q        : modulus the downstream modular_subtractor reduces by
//   id_width : bits needed to name one of n requesters (at least 1)
// -----------------------------------------------------------------------------
package modsub_arbiter_pkg;

  localparam int DEF_W    = 30;
  localparam int DEF_NREQ = 2;
  localparam int unsigned Q = 32'd1073479681;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modsub_tag_pipe.sv
// -----------------------------------------------------------------------------
// modsub_tag_pipe
//   Shift register of {valid, requester id} tags, DEPTH stages deep, that
//   advances every cycle. It tracks which requester owns each operation while
//   the operands travel through the shared subtractor.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset (clears valids)
//   in_valid, in_id     : tag entering stage 0
//   out_valid, out_id   : tag leaving the last stage
// -----------------------------------------------------------------------------
module modsub_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int IDW   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [IDW-1:0] in_id,
  output logic           out_valid,
  output logic [IDW-1:0] out_id
);

  logic [DEPTH-1:0] stage_valid;
  logic [IDW-1:0]   stage_id [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_id[i] <= '0;
      end
    end else begin
      stage_valid[0] <= in_valid;
      stage_id[0]    <= in_id;
      for (int i = 1; i < DEPTH; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_id[i]    <= stage_id[i-1];
      end
    end
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign out_id    = stage_id[DEPTH-1];

endmodule

// File: rtl/modsub_arbiter.sv
// -----------------------------------------------------------------------------
// modsub_arbiter
//   Shares one modular_subtractor between NREQ requesters. A round-robin
//   arbiter picks at most one request per cycle, registers its operands onto
//   sub_a/sub_b, and a tag pipeline routes the returning sub_c back to the
//   owner as a registered one-hot rsp_valid with rsp_data.
//
// Handshake: requester i transfers on the rising edge where
//   req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and
//   the round-robin pointer, is one-hot or zero, and is zero during reset.
//   There is no backpressure: a transfer always produces exactly one
//   rsp_valid pulse 1+SUB_LAT cycles later, and responses return in order.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester request handshake
//   req_a, req_b         : packed operands, requester i at [i*W +: W]
//   sub_a, sub_b, sub_c  : operands to / result from the shared subtractor
//   rsp_valid, rsp_data  : one-hot result strobe and shared result bus
//   inflight             : operations accepted but not yet returned
// -----------------------------------------------------------------------------
module modsub_arbiter
  import modsub_arbiter_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int NREQ    = DEF_NREQ,
  parameter int SUB_LAT = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*W-1:0]               req_a,
  input  logic [NREQ*W-1:0]               req_b,
  output logic [W-1:0]                    sub_a,
  output logic [W-1:0]                    sub_b,
  input  logic [W-1:0]                    sub_c,
  output logic [NREQ-1:0]                 rsp_valid,
  output logic [W-1:0]                    rsp_data,
  output logic [$clog2(SUB_LAT+2):0]      inflight
);

  localparam int IDW   = id_width(NREQ);
  localparam int DEPTH = 1 + SUB_LAT;
  localparam int CW    = $clog2(SUB_LAT+2) + 1;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [NREQ-1:0] gnt_oh;
  logic            xfer;
  int              scan_idx;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            tail_valid;
  logic [IDW-1:0]  tail_id;
  logic [NREQ-1:0] tail_oh;

  // Round-robin scan: walk offsets from high to low so the smallest offset
  // from ptr with a valid request is the one left standing.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_id  = scan_idx[IDW-1:0];
      end
    end
  end

  // Gating with rst_n keeps req_ready low while the block is held in reset.
  always_comb begin
    gnt_oh = '0;
    if (gnt_any && rst_n) begin
      gnt_oh[gnt_id] = 1'b1;
    end
  end

  assign req_ready = gnt_oh;
  assign xfer      = |gnt_oh;

  // Operand select for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(gnt_id) == i) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Pointer and operand registers. Operands hold when idle so the
  // subtractor input does not toggle without a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      sub_a <= '0;
      sub_b <= '0;
    end else if (xfer) begin
      sub_a <= sel_a;
      sub_b <= sel_b;
      if (int'(gnt_id) == NREQ - 1) begin
        ptr <= '0;
      end else begin
        ptr <= gnt_id + 1'b1;
      end
    end
  end

  // One stage covers the operand register, SUB_LAT stages cover the
  // subtractor; the tail tag lines up with the sub_c for that operation.
  modsub_tag_pipe #(
    .DEPTH (DEPTH),
    .IDW   (IDW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (xfer),
    .in_id     (gnt_id),
    .out_valid (tail_valid),
    .out_id    (tail_id)
  );

  always_comb begin
    tail_oh = '0;
    if (tail_valid) begin
      tail_oh[tail_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tail_oh;
      if (tail_valid) begin
        rsp_data <= sub_c;
      end
    end
  end

  // The decrement is taken on the edge that raises rsp_valid, so an
  // operation counts from its transfer edge to its response edge; with
  // back-to-back traffic that bounds the count at 1+SUB_LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({xfer, tail_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_modsub_arbiter.sv
module tb_modsub_arbiter;
  import modsub_arbiter_pkg::*;

  localparam int W       = 30;
  localparam int NREQ    = 2;
  localparam int SUB_LAT = 1;
  localparam int CW      = $clog2(SUB_LAT+2) + 1;
  localparam logic [W:0] QM = 31'(Q);

  // ---------------- clock / reset / signals ----------------
  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      sub_a;
  logic [W-1:0]      sub_b;
  logic [W-1:0]      sub_c;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [CW-1:0]     inflight;

  int n_vec;
  int n_err;

  logic [W-1:0] exp_q[$];
  int           exp_id_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  modsub_arbiter #(.W(W), .NREQ(NREQ), .SUB_LAT(SUB_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .sub_c     (sub_c),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .inflight  (inflight)
  );

  // ---------------- subtractor model: (a - b) mod Q, SUB_LAT cycles ----------
  function automatic logic [W-1:0] modsub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + QM - {1'b0, b};
    return d[W-1:0];
  endfunction

  logic [W-1:0] sub_pipe [SUB_LAT];
  always @(posedge clk) begin
    sub_pipe[0] <= modsub(sub_a, sub_b);
    for (int i = 1; i < SUB_LAT; i++) sub_pipe[i] <= sub_pipe[i-1];
  end
  assign sub_c = sub_pipe[SUB_LAT-1];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]      = v;
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = {30'd5, 30'd9};
    req_b     = {30'd3, 30'd2};
    tick();
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    n_vec++; if (sub_a !== 30'd0) begin n_err++; $display("FAIL reset_sub_a: got %0d want 0", sub_a); end
    n_vec++; if (sub_b !== 30'd0) begin n_err++; $display("FAIL reset_sub_b: got %0d want 0", sub_b); end
    n_vec++; if (rsp_data !== 30'd0) begin n_err++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 30'd1, 30'd1063321600);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick();
    set_req(0, 1'b0, 30'd1, 30'd1063321600);
    n_vec++; if (sub_a !== 30'd1) begin n_err++; $display("FAIL single_sub_a: got %0d want 1", sub_a); end
    n_vec++; if (sub_b !== 30'd1063321600) begin n_err++; $display("FAIL single_sub_b: got %0d want 1063321600", sub_b); end
    n_vec++; if (inflight !== 3'd1) begin n_err++; $display("FAIL single_inflight1: got %0d want 1", inflight); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early1: got %b want 00", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early2: got %b want 00", rsp_valid); end
    n_vec++; if (inflight !== 3'd1) begin n_err++; $display("FAIL single_inflight2: got %0d want 1", inflight); end
    tick();
    n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    n_vec++; if (rsp_data !== 30'd10158082) begin n_err++; $display("FAIL single_rsp_data: got %0d want 10158082", rsp_data); end
    n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL single_inflight3: got %0d want 0", inflight); end
    tick();
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_rsp_drop: got %b want 00", rsp_valid); end
    n_vec++; if (rsp_data !== 30'd10158082) begin n_err++; $display("FAIL single_rsp_hold: got %0d want 10158082", rsp_data); end
  endtask

  task automatic test_arbitration();
    apply_reset();
    set_req(0, 1'b1, 30'd100, 30'd23);
    set_req(1, 1'b1, 30'd0, 30'd0);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL arb_first: got %b want 01", req_ready); end
    tick();
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL arb_second: got %b want 10", req_ready); end
    n_vec++; if (sub_a !== 30'd100 || sub_b !== 30'd23) begin n_err++; $display("FAIL arb_ops0: got %0d,%0d want 100,23", sub_a, sub_b); end
    n_vec++; if (inflight !== 3'd1) begin n_err++; $display("FAIL arb_inflight1: got %0d want 1", inflight); end
    tick();
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL arb_wrap: got %b want 01", req_ready); end
    req_valid = '0;
    n_vec++; if (sub_a !== 30'd0 || sub_b !== 30'd0) begin n_err++; $display("FAIL arb_ops1: got %0d,%0d want 0,0", sub_a, sub_b); end
    n_vec++; if (inflight !== 3'd2) begin n_err++; $display("FAIL arb_inflight2: got %0d want 2", inflight); end
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL arb_early: got %b want 00", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 2'b01 || rsp_data !== 30'd77) begin n_err++; $display("FAIL arb_rsp0: got %b/%0d want 01/77", rsp_valid, rsp_data); end
    n_vec++; if (inflight !== 3'd1) begin n_err++; $display("FAIL arb_inflight3: got %0d want 1", inflight); end
    tick();
    n_vec++; if (rsp_valid !== 2'b10 || rsp_data !== 30'd0) begin n_err++; $display("FAIL arb_rsp1: got %b/%0d want 10/0", rsp_valid, rsp_data); end
    n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL arb_inflight4: got %0d want 0", inflight); end
    tick();
    n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL arb_rsp_drop: got %b want 00", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]    a0, b0, a1, b1;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_oh;
    logic [W-1:0]    exp_d;
    int              exp_id, e, t, r, exp_if;
    // Pointer is 0 here: the last grant went to requester 1.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        a0 = W'(1000 * k + 17);
        b0 = W'(50000 * k);
        a1 = W'(123456 * k);
        b1 = W'(99 + k);
        set_req(0, 1'b1, a0, b0);
        set_req(1, 1'b1, a1, b1);
        #1;
        exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_grant k=%0d: got %b want %b", k, req_ready, exp_rdy); end
        exp_id_q.push_back(k % 2);
        exp_q.push_back((k % 2 == 0) ? modsub(a0, b0) : modsub(a1, b1));
      end else begin
        req_valid = '0;
      end
      tick();
      e = k + 1;
      t = (e < 8) ? e : 8;
      r = (e >= 3) ? ((e - 2 < 8) ? e - 2 : 8) : 0;
      exp_if = t - r;
      n_vec++; if (int'(inflight) != exp_if) begin n_err++; $display("FAIL b2b_inflight e=%0d: got %0d want %0d", e, inflight, exp_if); end
      if (e >= 3 && e <= 10) begin
        exp_d  = exp_q.pop_front();
        exp_id = exp_id_q.pop_front();
        exp_oh = '0;
        exp_oh[exp_id] = 1'b1;
        n_vec++; if (rsp_valid !== exp_oh || rsp_data !== exp_d) begin n_err++; $display("FAIL b2b_rsp e=%0d: got %b/%0d want %b/%0d", e, rsp_valid, rsp_data, exp_oh, exp_d); end
      end else begin
        n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL b2b_norsp e=%0d: got %b want 00", e, rsp_valid); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b1, 30'd40, 30'd30);
    set_req(1, 1'b1, 30'd8, 30'd9);
    tick();
    tick();
    tick();
    // Grants went 0,1,0: pointer now 1, two operations still outstanding.
    n_vec++; if (inflight !== 3'd2) begin n_err++; $display("FAIL mid_inflight_pre: got %0d want 2", inflight); end
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL mid_ptr_pre: got %b want 10", req_ready); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL mid_ready_in_reset: got %b want 00", req_ready); end
    n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL mid_inflight_async: got %0d want 0", inflight); end
    n_vec++; if (sub_a !== 30'd0) begin n_err++; $display("FAIL mid_sub_a_async: got %0d want 0", sub_a); end
    tick();
    tick();
    req_valid = '0;
    rst_n     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_stale_rsp k=%0d: got %b want 00", k, rsp_valid); end
      n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL mid_inflight k=%0d: got %0d want 0", k, inflight); end
    end
    set_req(0, 1'b1, 30'd500, 30'd600);
    set_req(1, 1'b1, 30'd7, 30'd7);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_ptr_reset: got %b want 01", req_ready); end
  endtask

  task automatic test_idle();
    tick();
    req_valid = '0;
    n_vec++; if (sub_a !== 30'd500 || sub_b !== 30'd600) begin n_err++; $display("FAIL idle_ops: got %0d,%0d want 500,600", sub_a, sub_b); end
    tick();
    tick();
    n_vec++; if (rsp_valid !== 2'b01 || rsp_data !== 30'd1073479581) begin n_err++; $display("FAIL idle_last_rsp: got %b/%0d want 01/1073479581", rsp_valid, rsp_data); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if (sub_a !== 30'd500 || sub_b !== 30'd600) begin n_err++; $display("FAIL idle_hold_ops k=%0d: got %0d,%0d want 500,600", k, sub_a, sub_b); end
      n_vec++; if (rsp_data !== 30'd1073479581) begin n_err++; $display("FAIL idle_hold_data k=%0d: got %0d want 1073479581", k, rsp_data); end
      n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL idle_rsp_valid k=%0d: got %b want 00", k, rsp_valid); end
      n_vec++; if (inflight !== 3'd0) begin n_err++; $display("FAIL idle_inflight k=%0d: got %0d want 0", k, inflight); end
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL idle_ready k=%0d: got %b want 00", k, req_ready); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_arbitration();
    test_back_to_back();
    test_reset_midflight();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
